pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and stall sequencer for the five-stage MIPS pipeline. It drives the enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers. It detects load-use hazards between ID and EX, squashes wrong-path instructions on a taken branch resolved in EX, and freezes the whole pipeline while a data-memory access is outstanding. It also keeps saturating stall and flush counters for performance analysis.

## Interface
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3)
- MEM_TIMEOUT, 255, maximum consecutive memory wait cycles before mem_err is raised (1..255)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, store, beq/bne)
- ex_rt  in  5  destination rt of the instruction in ID/EX
- ex_memtoreg  in  1  ID/EX instruction is a load
- ex_regwrite  in  1  ID/EX instruction writes the register file
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- mem_req  in  1  EX/MEM instruction accesses data memory this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a nop
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX loads a bubble (all control fields 0)
- exmem_en  out  1  EX/MEM and MEM/WB load enable
- stall_cnt  out  16  saturating count of cycles with pc_en=0 outside reset
- flush_cnt  out  16  saturating count of taken-branch flushes
- mem_err  out  1  sticky memory-timeout flag

## Operation
- States: RUN, LU_STALL, MEM_WAIT. Reset: state=RUN, lu_cnt=0, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_err=0.
- While rst=1, outputs are pc_en=ifid_en=idex_en=exmem_en=0 and ifid_flush=idex_flush=1.
- freeze = mem_req & ~mem_ready.
- lu_hit = ex_memtoreg & ex_regwrite & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Per-cycle priority: freeze > ex_branch_taken > load-use > normal.
- freeze (any state): all four enables are 0 and both flushes are 0. State goes to MEM_WAIT. wait_cnt increments, saturating at 255. If wait_cnt reaches MEM_TIMEOUT, mem_err is set. It stays set until reset.
- MEM_WAIT with mem_ready=1: the cycle behaves as RUN with normal priority. wait_cnt clears. The next state is RUN, or LU_STALL if lu_hit is also present.
- Branch taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=1. flush_cnt increments. A branch in LU_STALL aborts the stall: lu_cnt clears and state goes to RUN.
- Load-use from RUN: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1. Go to LU_STALL with lu_cnt=1. If LU_STALL_CYCLES=1, go back to RUN instead.
- LU_STALL: same outputs as load-use. lu_cnt increments. When lu_cnt==LU_STALL_CYCLES, go to RUN. lu_hit is not re-evaluated in LU_STALL, because ID/EX now holds a bubble.
- Normal: all enables are 1 and both flushes are 0.
- stall_cnt increments in every non-reset cycle with pc_en=0 and saturates at 0xFFFF. flush_cnt also saturates at 0xFFFF.

## Timing
- All control outputs are combinational from the current state and inputs, so they gate the same clock edge. Counters and state register on posedge clk.
- Load-use costs exactly LU_STALL_CYCLES bubbles. A taken branch costs 2 squashed slots with 0 stall cycles.
- Memory wait holds the pipeline for N cycles, where N is the number of cycles in which mem_ready=0 while mem_req=1.
- Reset asserted mid-stall or mid-wait returns to RUN on the next edge and clears all counters.

## Test plan
- Load `lw $5` in EX with id_rs=5, LU_STALL_CYCLES=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1; next cycle all enables are 1.
- ex_rt=0 with ex_memtoreg=1 and id_rs=0 -> no stall.
- id_rt match with id_uses_rt=0 -> no stall.
- ex_branch_taken=1 and lu_hit=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- mem_req=1 with mem_ready low for 3 cycles -> 3 cycles with all enables 0, stall_cnt=3; release cycle has all enables 1.
- MEM_TIMEOUT=4, mem_ready held low for 6 cycles -> mem_err rises on the cycle wait_cnt reaches 4 and stays set after release, until rst.
- LU_STALL_CYCLES=3, rst asserted during the second stall cycle -> state RUN, counters 0; after rst deasserts, enables are 1 with no residual stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the five-stage MIPS pipeline: load-use bubbles,
// taken-branch squash, memory-wait freeze, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_memtoreg,
  input  logic        ex_regwrite,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_err
);

  typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

  localparam logic [1:0] LuLast    = 2'(LU_STALL_CYCLES);
  localparam logic [7:0] WaitLimit = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [1:0]  lu_cnt_q, lu_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        mem_err_q, mem_err_d;
  logic        freeze, lu_hit, flush_inc, stall_inc;

  assign freeze = mem_req & ~mem_ready;
  assign lu_hit = ex_memtoreg & ex_regwrite & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    flush_inc  = 1'b0;

    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_en    = 1'b0;
      idex_flush = 1'b1;
      exmem_en   = 1'b0;
    end else if (freeze) begin
      // Whole pipeline holds; lu_cnt is kept, load-use is re-judged on release.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      state_d    = StMemWait;
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
      if (wait_cnt_d >= WaitLimit) begin
        mem_err_d = 1'b1;
      end
    end else begin
      wait_cnt_d = 8'd0;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
        state_d    = StRun;
        lu_cnt_d   = 2'd0;
      end else if (state_q == StLuStall) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        if (lu_cnt_q + 2'd1 == LuLast) begin
          state_d  = StRun;
          lu_cnt_d = 2'd0;
        end else begin
          lu_cnt_d = lu_cnt_q + 2'd1;
        end
      end else if (lu_hit) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        if (LuLast == 2'd1) begin
          state_d  = StRun;
          lu_cnt_d = 2'd0;
        end else begin
          state_d  = StLuStall;
          lu_cnt_d = 2'd1;
        end
      end else begin
        state_d  = StRun;
        lu_cnt_d = 2'd0;
      end
    end
  end

  assign stall_inc = ~rst & ~pc_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      lu_cnt_q    <= 2'd0;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush_inc && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (1-cycle and 3-cycle load-use, short and long timeout)
// share one stimulus stream; expected outputs are queued per cycle and checked at negedge.
module tb_pipeline_hazard_ctrl;

  // Control packing: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  localparam logic [5:0] NRM = 6'b110101;
  localparam logic [5:0] LUO = 6'b000111;
  localparam logic [5:0] BRO = 6'b111111;
  localparam logic [5:0] FRZ = 6'b000000;
  localparam logic [5:0] RSO = 6'b001010;

  typedef struct {
    logic [5:0]  ctl_a;
    logic [5:0]  ctl_b;
    logic [15:0] st_a;
    logic [15:0] st_b;
    logic [15:0] fl;
    logic        err_a;
    logic        err_b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_memtoreg, ex_regwrite, ex_branch_taken, mem_req, mem_ready;

  logic pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a, exmem_en_a, mem_err_a;
  logic pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_flush_b, exmem_en_b, mem_err_b;
  logic [15:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_idx  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a), .idex_en(idex_en_a),
    .idex_flush(idex_flush_a), .exmem_en(exmem_en_a), .stall_cnt(stall_cnt_a),
    .flush_cnt(flush_cnt_a), .mem_err(mem_err_a)
  );

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b), .idex_en(idex_en_b),
    .idex_flush(idex_flush_b), .exmem_en(exmem_en_b), .stall_cnt(stall_cnt_b),
    .flush_cnt(flush_cnt_b), .mem_err(mem_err_b)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, vec_idx, act, req);
    end
  endtask

  // Monitor: the DUT presents a new control word every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ctl_a", {10'd0, pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a,
                    exmem_en_a}, {10'd0, e.ctl_a});
      chk("ctl_b", {10'd0, pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_flush_b,
                    exmem_en_b}, {10'd0, e.ctl_b});
      chk("stall_cnt_a", stall_cnt_a, e.st_a);
      chk("stall_cnt_b", stall_cnt_b, e.st_b);
      chk("flush_cnt_a", flush_cnt_a, e.fl);
      chk("flush_cnt_b", flush_cnt_b, e.fl);
      chk("mem_err_a", {15'd0, mem_err_a}, {15'd0, e.err_a});
      chk("mem_err_b", {15'd0, mem_err_b}, {15'd0, e.err_b});
      vec_idx++;
    end
  end

  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ut, input logic [4:0] ert, input logic mtr, input logic rw,
                      input logic br, input logic mq, input logic mr,
                      input logic [5:0] ca, input logic [5:0] cb,
                      input int sa, input int sb, input int f,
                      input logic ea, input logic eb);
    exp_t e;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = ut; ex_rt = ert;
    ex_memtoreg = mtr; ex_regwrite = rw; ex_branch_taken = br;
    mem_req = mq; mem_ready = mr;
    e.ctl_a = ca; e.ctl_b = cb;
    e.st_a = 16'(sa); e.st_b = 16'(sb); e.fl = 16'(f);
    e.err_a = ea; e.err_b = eb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [5:0] ca, input logic [5:0] cb,
                      input int sa, input int sb, input int f,
                      input logic ea, input logic eb);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ca, cb, sa, sb, f, ea, eb);
  endtask

  task automatic frz(input int sa, input int sb, input int f, input logic ea);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, FRZ, sa, sb, f, ea, 0);
  endtask

  initial begin
    rst = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rt = 0;
    ex_memtoreg = 0; ex_regwrite = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    @(posedge clk);
    #1;
    //   r rs rt ut ert mtr rw br mq mr  ctl_a ctl_b  sa sb f  ea eb
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSO, RSO, 0, 0, 0, 0, 0);
    idle(NRM, NRM, 0, 0, 0, 0, 0);
    // Load-use on rs: A stalls once, B stalls three cycles
    step(0, 5, 0, 0, 5, 1, 1, 0, 0, 0, LUO, LUO, 0, 0, 0, 0, 0);
    idle(NRM, LUO, 1, 1, 0, 0, 0);
    idle(NRM, LUO, 1, 2, 0, 0, 0);
    idle(NRM, NRM, 1, 3, 0, 0, 0);
    // No-hazard cases: $0 destination, rt unused, non-writing load
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, NRM, NRM, 1, 3, 0, 0, 0);
    step(0, 3, 7, 0, 7, 1, 1, 0, 0, 0, NRM, NRM, 1, 3, 0, 0, 0);
    step(0, 7, 0, 0, 7, 1, 0, 0, 0, 0, NRM, NRM, 1, 3, 0, 0, 0);
    // rt hazard, then branch in the same cycle as a new hazard (aborts B's stall)
    step(0, 3, 7, 1, 7, 1, 1, 0, 0, 0, LUO, LUO, 1, 3, 0, 0, 0);
    step(0, 5, 0, 0, 5, 1, 1, 1, 0, 0, BRO, BRO, 2, 4, 0, 0, 0);
    idle(NRM, NRM, 2, 4, 1, 0, 0);
    // Three-cycle memory wait
    frz(2, 4, 1, 0);
    frz(3, 5, 1, 0);
    frz(4, 6, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM, NRM, 5, 7, 1, 0, 0);
    idle(NRM, NRM, 5, 7, 1, 0, 0);
    // Six-cycle wait: A times out after its fourth wait cycle
    frz(5, 7, 1, 0);
    frz(6, 8, 1, 0);
    frz(7, 9, 1, 0);
    frz(8, 10, 1, 0);
    frz(9, 11, 1, 1);
    frz(10, 12, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM, NRM, 11, 13, 1, 1, 0);
    idle(NRM, NRM, 11, 13, 1, 1, 0);
    // Release cycle with a load-use hazard present
    frz(11, 13, 1, 1);
    step(0, 5, 0, 0, 5, 1, 1, 0, 1, 1, LUO, LUO, 12, 14, 1, 1, 0);
    // Reset during B's second stall cycle
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSO, RSO, 13, 15, 1, 1, 0);
    idle(NRM, NRM, 0, 0, 0, 0, 0);
    idle(NRM, NRM, 0, 0, 0, 0, 0);
    // Freeze outranks branch and load-use
    step(0, 5, 0, 0, 5, 1, 1, 1, 1, 0, FRZ, FRZ, 0, 0, 0, 0, 0);
    idle(NRM, NRM, 1, 1, 0, 0, 0);
    idle(NRM, NRM, 1, 1, 0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
